// File: rtl/sprite_pkg.sv
// Shared definitions for the scene sprite controllers: slider FSM states,
// keyboard codes and scene status codes.
// Optional feature macro: SPRITE_SLIDER_AUTO_EN adds the automatic-travel states.
package sprite_pkg;

    // Keyboard scan codes used by the sliding sprites
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    // Scene status codes driven by the status logic
    localparam logic [3:0] SCENE_TITLE = 4'd0;
    localparam logic [3:0] SCENE_HALL  = 4'd1;
    localparam logic [3:0] SCENE_ROOM  = 4'd2;
    localparam logic [3:0] SCENE_DOOR  = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MAN_NEG  = 3'd1,
        S_MAN_POS  = 3'd2
`ifdef SPRITE_SLIDER_AUTO_EN
        ,
        S_AUTO_NEG = 3'd3,
        S_AUTO_POS = 3'd4
`endif
    } slider_state_t;

endpackage

// File: rtl/frame_tick.sv
// Rising-edge detector for the vsync-rate frame strobe. Produces a single
// Clk-wide pulse per frame; reusable by every sprite controller.
module frame_tick (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_pulse
);

    logic r_prev;

    // Remember the strobe level seen on the previous clock
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create simulation order races.
        if (!i_rst_n) r_prev <= 1'b0;
        else          r_prev <= i_level;
    end

    assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/sprite_slider.sv
// Slides a rectangular sprite along one screen axis between two clamped
// limits, driven by a held key (manual) or a one-cycle request (automatic).
// Also decodes window membership and ROM address for the current pixel.
// Optional feature macro: SPRITE_SLIDER_AUTO_EN enables auto_req/busy/done.
module sprite_slider
    import sprite_pkg::*;
#(
    parameter int         SPR_W           = 182,
    parameter int         SPR_H           = 158,
    parameter int         AXIS_Y          = 0,
    parameter int         FIXED_COORD     = 22,
    parameter int         POS_MIN         = 458,
    parameter int         POS_MAX         = 698,
    parameter int         POS_INIT        = 698,
    parameter int         STEP            = 1,
    parameter int         FRAMES_PER_STEP = 1,
    parameter logic [3:0] ACTIVE_STATUS   = SCENE_DOOR,
    parameter logic [7:0] KEY_NEG         = KEY_D,
    parameter logic [7:0] KEY_POS         = KEY_A,
    parameter int         ADDR_W          = 20
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [3:0]        status,
    input  logic [7:0]        keycode,
    input  logic              auto_req,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic              is_sprite,
    output logic [ADDR_W-1:0] sprite_address,
    output logic [9:0]        pos,
    output logic              at_min,
    output logic              at_max,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    // Extent along the slide axis (a) and along the fixed axis (b)
    localparam int EXT_A = (AXIS_Y != 0) ? SPR_H : SPR_W;
    localparam int EXT_B = (AXIS_Y != 0) ? SPR_W : SPR_H;

    slider_state_t    r_state, w_state_next;
    logic [9:0]       r_pos, w_pos_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             w_tick, w_step, w_active;
    logic             w_at_min, w_at_max;
    logic             w_move_neg, w_move_pos;
    logic [10:0]      w_pos11;

    frame_tick u_frame_tick (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_level (frame_clk),
        .o_pulse (w_tick)
    );

    assign w_active = (status == ACTIVE_STATUS);
    assign w_at_min = (r_pos == 10'(POS_MIN));
    assign w_at_max = (r_pos == 10'(POS_MAX));
    assign w_step   = w_tick && (r_cnt == CNT_W'(FRAMES_PER_STEP - 1));
    assign w_pos11  = {1'b0, r_pos};

`ifdef SPRITE_SLIDER_AUTO_EN
    localparam int POS_MID = (POS_MIN + POS_MAX) / 2;
`else
    logic w_unused_auto_req;
    assign w_unused_auto_req = auto_req;
`endif

    // Next-state decode: auto request beats keycode; keys are sampled on ticks
    always_comb begin
        // NOTE: assigning the default first gives every path a value, so no
        // latch is inferred when a branch leaves the signal untouched.
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_MAN_NEG, S_MAN_POS: begin
`ifdef SPRITE_SLIDER_AUTO_EN
                if (auto_req) begin
                    w_state_next = (w_pos11 > 11'(POS_MID)) ? S_AUTO_NEG : S_AUTO_POS;
                end else
`endif
                if (w_tick) begin
                    if (keycode == KEY_NEG)      w_state_next = S_MAN_NEG;
                    else if (keycode == KEY_POS) w_state_next = S_MAN_POS;
                    else                         w_state_next = S_IDLE;
                end
            end
`ifdef SPRITE_SLIDER_AUTO_EN
            S_AUTO_NEG: if (w_at_min) w_state_next = S_IDLE;
            S_AUTO_POS: if (w_at_max) w_state_next = S_IDLE;
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // Movement: manual only while staying in its state, automatic on every step
    always_comb begin
        w_move_neg = w_step && (r_state == S_MAN_NEG) && (w_state_next == S_MAN_NEG);
        w_move_pos = w_step && (r_state == S_MAN_POS) && (w_state_next == S_MAN_POS);
`ifdef SPRITE_SLIDER_AUTO_EN
        if (w_step && (r_state == S_AUTO_NEG)) w_move_neg = 1'b1;
        if (w_step && (r_state == S_AUTO_POS)) w_move_pos = 1'b1;
`endif
        w_pos_next = r_pos;
        if (w_move_neg) begin
            w_pos_next = (w_pos11 < 11'(POS_MIN + STEP)) ? 10'(POS_MIN)
                                                         : 10'(w_pos11 - 11'(STEP));
        end else if (w_move_pos) begin
            w_pos_next = ((w_pos11 + 11'(STEP)) > 11'(POS_MAX)) ? 10'(POS_MAX)
                                                                : 10'(w_pos11 + 11'(STEP));
        end
    end

    // Step counter: wraps every FRAMES_PER_STEP ticks, restarts on state change
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_state_next != r_state) w_cnt_next = '0;
        else if (w_step)             w_cnt_next = '0;
        else if (w_tick)             w_cnt_next = r_cnt + 1'b1;
    end

    // State, position and counter registers; leaving the scene reloads them
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_pos   <= 10'(POS_INIT);
            r_cnt   <= '0;
        end else if (!w_active) begin
            r_state <= S_IDLE;
            r_pos   <= 10'(POS_INIT);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pos   <= w_pos_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign pos    = r_pos;
    assign at_min = w_at_min;
    assign at_max = w_at_max;

`ifdef SPRITE_SLIDER_AUTO_EN
    assign busy = w_active && ((r_state == S_AUTO_NEG) || (r_state == S_AUTO_POS));
    assign done = w_active && (((r_state == S_AUTO_NEG) && w_at_min) ||
                               ((r_state == S_AUTO_POS) && w_at_max));
`else
    assign busy = 1'b0;
    assign done = 1'b0;
`endif

    // Pixel path: a is the slide-axis coordinate, b the fixed-axis coordinate.
    // Offsets are unsigned; the a >= pos guard makes the wrap-around harmless.
    logic [9:0]  w_a, w_b;
    logic [10:0] w_a_off, w_b_off, w_col, w_row;
    logic        w_inside;

    assign w_a      = (AXIS_Y != 0) ? DrawY : DrawX;
    assign w_b      = (AXIS_Y != 0) ? DrawX : DrawY;
    assign w_a_off  = {1'b0, w_a} - w_pos11;
    assign w_b_off  = {1'b0, w_b} - 11'(FIXED_COORD);
    assign w_inside = w_active
                   && (w_a >= r_pos) && (w_a_off < 11'(EXT_A))
                   && ({1'b0, w_b} >= 11'(FIXED_COORD)) && (w_b_off < 11'(EXT_B));
    assign w_col    = (AXIS_Y != 0) ? w_b_off : w_a_off;
    assign w_row    = (AXIS_Y != 0) ? w_a_off : w_b_off;

    assign is_sprite      = w_inside;
    assign sprite_address = w_inside ? (ADDR_W'(w_col) + ADDR_W'(w_row) * ADDR_W'(SPR_W))
                                     : '0;

endmodule

// File: tb/tb_sprite_slider.sv
// Directed self-checking bench for sprite_slider. A second instance with a
// four-frame step divider, starting at the lower limit, covers the divider.
`timescale 1ns/1ps
module tb_sprite_slider;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_clk = 1'b0;
    logic [3:0]  status = 4'd3;
    logic [7:0]  keycode = 8'h00;
    logic        auto_req = 1'b0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic        is_sprite;
    logic [19:0] sprite_address;
    logic [9:0]  pos;
    logic        at_min, at_max, busy, done;

    logic [3:0]  status4 = 4'd0;
    logic [7:0]  key4 = 8'h00;
    logic        is_sprite4;
    logic [19:0] sprite_address4;
    logic [9:0]  pos4;
    logic        at_min4, at_max4, busy4, done4;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) if (done === 1'b1) done_cnt++;

    sprite_slider dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .status(status),
        .keycode(keycode), .auto_req(auto_req), .DrawX(DrawX), .DrawY(DrawY),
        .is_sprite(is_sprite), .sprite_address(sprite_address), .pos(pos),
        .at_min(at_min), .at_max(at_max), .busy(busy), .done(done)
    );

    sprite_slider #(.FRAMES_PER_STEP(4), .POS_INIT(458)) dut4 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .status(status4),
        .keycode(key4), .auto_req(1'b0), .DrawX(DrawX), .DrawY(DrawY),
        .is_sprite(is_sprite4), .sprite_address(sprite_address4), .pos(pos4),
        .at_min(at_min4), .at_max(at_max4), .busy(busy4), .done(done4)
    );

    // One frame strobe per call; the position update lands before return
    task automatic frame_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk) frame_clk = 1'b1;
            @(negedge Clk) frame_clk = 1'b0;
            @(negedge Clk);
        end
    endtask

    // Leave the scene briefly so the sprite reloads POS_INIT
    task automatic reload_scene();
        @(negedge Clk) status = 4'd1;
        @(negedge Clk);
        @(negedge Clk) status = 4'd3;
        @(negedge Clk);
    endtask

    task automatic pulse_auto();
        @(negedge Clk) auto_req = 1'b1;
        @(negedge Clk) auto_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        @(negedge Clk);
        n_cmp++; if (pos !== 10'd698) begin n_err++; $display("FAIL reset_pos got %0d want 698", pos); end
        n_cmp++; if (at_max !== 1'b1 || at_min !== 1'b0) begin n_err++; $display("FAIL reset_limits got max=%b min=%b want 1/0", at_max, at_min); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done got %b/%b want 0/0", busy, done); end
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk);
        n_cmp++; if (pos !== 10'd698) begin n_err++; $display("FAIL release_pos got %0d want 698", pos); end
        DrawX = 10'd700; DrawY = 10'd22; #1;
        n_cmp++; if (is_sprite !== 1'b1 || sprite_address !== 20'd2) begin n_err++; $display("FAIL pix_700_22 got %b/%0d want 1/2", is_sprite, sprite_address); end
        DrawX = 10'd697; #1;
        n_cmp++; if (is_sprite !== 1'b0 || sprite_address !== 20'd0) begin n_err++; $display("FAIL pix_697_22 got %b/%0d want 0/0", is_sprite, sprite_address); end
        DrawX = 10'd879; #1;
        n_cmp++; if (is_sprite !== 1'b1 || sprite_address !== 20'd181) begin n_err++; $display("FAIL pix_879_22 got %b/%0d want 1/181", is_sprite, sprite_address); end
        DrawX = 10'd880; #1;
        n_cmp++; if (is_sprite !== 1'b0) begin n_err++; $display("FAIL pix_880_22 got %b want 0", is_sprite); end
        DrawX = 10'd700; DrawY = 10'd179; #1;
        n_cmp++; if (is_sprite !== 1'b1 || sprite_address !== 20'd28576) begin n_err++; $display("FAIL pix_700_179 got %b/%0d want 1/28576", is_sprite, sprite_address); end
        DrawY = 10'd180; #1;
        n_cmp++; if (is_sprite !== 1'b0) begin n_err++; $display("FAIL pix_700_180 got %b want 0", is_sprite); end
        DrawY = 10'd21; #1;
        n_cmp++; if (is_sprite !== 1'b0) begin n_err++; $display("FAIL pix_700_21 got %b want 0", is_sprite); end
    endtask

    task automatic test_manual_neg();
        keycode = 8'h07;
        frame_ticks(1);   // enters MAN_NEG, no move yet
        n_cmp++; if (pos !== 10'd698) begin n_err++; $display("FAIL man_neg_entry got %0d want 698", pos); end
        frame_ticks(1);
        n_cmp++; if (pos !== 10'd697) begin n_err++; $display("FAIL man_neg_1 got %0d want 697", pos); end
        frame_ticks(10);
        n_cmp++; if (pos !== 10'd687 || at_max !== 1'b0) begin n_err++; $display("FAIL man_neg_11 got %0d max=%b want 687/0", pos, at_max); end
        frame_ticks(229);
        n_cmp++; if (pos !== 10'd458 || at_min !== 1'b1) begin n_err++; $display("FAIL man_neg_min got %0d min=%b want 458/1", pos, at_min); end
        frame_ticks(10);
        n_cmp++; if (pos !== 10'd458) begin n_err++; $display("FAIL man_neg_clamp got %0d want 458", pos); end
        keycode = 8'h00;
        frame_ticks(1);
    endtask

    task automatic test_manual_pos();
        keycode = 8'h04;
        frame_ticks(1);
        frame_ticks(5);
        n_cmp++; if (pos !== 10'd463 || at_min !== 1'b0) begin n_err++; $display("FAIL man_pos_5 got %0d min=%b want 463/0", pos, at_min); end
        keycode = 8'h00;
        frame_ticks(3);
        n_cmp++; if (pos !== 10'd463) begin n_err++; $display("FAIL man_release got %0d want 463", pos); end
    endtask

    task automatic test_step_divider();
        status4 = 4'd3;
        @(negedge Clk);
        @(negedge Clk);
        n_cmp++; if (pos4 !== 10'd458 || at_min4 !== 1'b1) begin n_err++; $display("FAIL div_start got %0d min=%b want 458/1", pos4, at_min4); end
        key4 = 8'h04;
        frame_ticks(1);   // enters MAN_POS, counter restarts
        frame_ticks(3);
        n_cmp++; if (pos4 !== 10'd458) begin n_err++; $display("FAIL div_3 got %0d want 458", pos4); end
        frame_ticks(1);
        n_cmp++; if (pos4 !== 10'd459) begin n_err++; $display("FAIL div_4 got %0d want 459", pos4); end
        frame_ticks(4);
        n_cmp++; if (pos4 !== 10'd460) begin n_err++; $display("FAIL div_8 got %0d want 460", pos4); end
        key4 = 8'h00;
        status4 = 4'd0;
    endtask

`ifdef SPRITE_SLIDER_AUTO_EN
    task automatic test_auto();
        reload_scene();
        n_cmp++; if (pos !== 10'd698) begin n_err++; $display("FAIL auto_reload got %0d want 698", pos); end
        done_cnt = 0;
        keycode = 8'h04;
        pulse_auto();
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL auto_busy got %b/%b want 1/0", busy, done); end
        frame_ticks(100);
        n_cmp++; if (pos !== 10'd598 || busy !== 1'b1) begin n_err++; $display("FAIL auto_100 got %0d busy=%b want 598/1", pos, busy); end
        frame_ticks(139);
        n_cmp++; if (pos !== 10'd459 || done_cnt !== 0) begin n_err++; $display("FAIL auto_239 got %0d done=%0d want 459/0", pos, done_cnt); end
        frame_ticks(1);
        n_cmp++; if (pos !== 10'd458 || done_cnt !== 1 || busy !== 1'b0) begin n_err++; $display("FAIL auto_end got %0d done=%0d busy=%b want 458/1/0", pos, done_cnt, busy); end
        keycode = 8'h00;
        frame_ticks(2);
        n_cmp++; if (pos !== 10'd458 || done_cnt !== 1) begin n_err++; $display("FAIL auto_idle got %0d done=%0d want 458/1", pos, done_cnt); end
    endtask

    task automatic test_scene_exit();
        reload_scene();
        pulse_auto();
        frame_ticks(98);
        n_cmp++; if (pos !== 10'd600 || busy !== 1'b1) begin n_err++; $display("FAIL exit_pre got %0d busy=%b want 600/1", pos, busy); end
        @(negedge Clk) status = 4'd1;
        @(negedge Clk);
        n_cmp++; if (pos !== 10'd698 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL exit_post got %0d busy=%b done=%b want 698/0/0", pos, busy, done); end
        DrawX = 10'd700; DrawY = 10'd22; #1;
        n_cmp++; if (is_sprite !== 1'b0) begin n_err++; $display("FAIL exit_pix_700 got %b want 0", is_sprite); end
        DrawX = 10'd650; #1;
        n_cmp++; if (is_sprite !== 1'b0 || sprite_address !== 20'd0) begin n_err++; $display("FAIL exit_pix_650 got %b/%0d want 0/0", is_sprite, sprite_address); end
        @(negedge Clk) status = 4'd3;
        @(negedge Clk);
    endtask

    task automatic test_reset_mid();
        pulse_auto();
        frame_ticks(5);
        n_cmp++; if (pos !== 10'd693) begin n_err++; $display("FAIL mid_pre got %0d want 693", pos); end
        #2 Reset = 1'b0;
        #1;
        n_cmp++; if (pos !== 10'd698 || busy !== 1'b0 || at_max !== 1'b1) begin n_err++; $display("FAIL mid_reset got %0d busy=%b max=%b want 698/0/1", pos, busy, at_max); end
        @(negedge Clk) begin Reset = 1'b1; auto_req = 1'b1; end
        @(negedge Clk) auto_req = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_release_req got busy=%b want 1", busy); end
        frame_ticks(2);
        n_cmp++; if (pos !== 10'd696) begin n_err++; $display("FAIL mid_resume got %0d want 696", pos); end
        reload_scene();
    endtask
`else
    task automatic test_auto_ignored();
        reload_scene();
        done_cnt = 0;
        keycode = 8'h00;
        pulse_auto();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL noauto_busy got %b want 0", busy); end
        frame_ticks(5);
        pulse_auto();
        frame_ticks(5);
        n_cmp++; if (pos !== 10'd698 || done_cnt !== 0) begin n_err++; $display("FAIL noauto_pos got %0d done=%0d want 698/0", pos, done_cnt); end
        keycode = 8'h07;
        @(negedge Clk) auto_req = 1'b1;
        @(negedge Clk) auto_req = 1'b0;
        frame_ticks(4);   // entry tick plus three steps
        n_cmp++; if (pos !== 10'd695 || busy !== 1'b0) begin n_err++; $display("FAIL noauto_manual got %0d busy=%b want 695/0", pos, busy); end
        keycode = 8'h00;
    endtask
`endif

    initial begin
        test_reset();
        test_manual_neg();
        test_manual_pos();
        test_step_divider();
`ifdef SPRITE_SLIDER_AUTO_EN
        test_auto();
        test_scene_exit();
        test_reset_mid();
`else
        test_auto_ignored();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
